// File: rtl/trivium_decryptor.sv
// Byte-stream Trivium decryptor: 1152-round warm-up, then 8 keystream bits per accepted byte.
// Optional TRIVIUM_DEC_KS_OUT_EN exposes the keystream byte used for out_data on ks_data.
module trivium_decryptor (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [79:0] key,
  input  logic [79:0] iv,
  output logic        busy,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data
`ifdef TRIVIUM_DEC_KS_OUT_EN
  , output logic [7:0] ks_data
`endif
);

  typedef enum logic [2:0] {IDLE, INIT, WAIT, GEN, OUT} state_t;

  state_t       state;
  logic [287:0] s;         // s[i-1] holds Trivium bit s(i)
  logic [287:0] s_next;
  logic [10:0]  cnt;
  logic [7:0]   byte_q;
  logic [7:0]   acc;
  logic         t1, t2, t3, z, t1n, t2n, t3n;
  logic [7:0]   ks_full;

  function automatic logic [287:0] load_state(input logic [79:0] k, input logic [79:0] v);
    logic [287:0] r;
    r = '0;
    for (int i = 0; i < 80; i++) begin
      r[i]      = k[79-i];
      r[93 + i] = v[79-i];
    end
    r[287:285] = 3'b111;
    return r;
  endfunction

  always_comb begin
    t1  = s[65]  ^ s[92];
    t2  = s[161] ^ s[176];
    t3  = s[242] ^ s[287];
    z   = t1 ^ t2 ^ t3;
    t1n = t1 ^ (s[90]  & s[91])  ^ s[170];
    t2n = t2 ^ (s[174] & s[175]) ^ s[263];
    t3n = t3 ^ (s[285] & s[286]) ^ s[68];
    s_next  = {s[286:177], t2n, s[175:93], t1n, s[91:0], t3n};
    ks_full = {z, acc[7:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      s         <= '0;
      cnt       <= '0;
      byte_q    <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef TRIVIUM_DEC_KS_OUT_EN
      ks_data   <= '0;
`endif
    end else if (start) begin
      // start overrides any handshake; any held byte is abandoned
      state     <= INIT;
      s         <= load_state(key, iv);
      cnt       <= '0;
      busy      <= 1'b1;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          s   <= s_next;
          cnt <= cnt + 11'd1;
          if (cnt == 11'd1151) begin
            state    <= WAIT;
            cnt      <= '0;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (in_valid) begin
            byte_q   <= in_data;
            in_ready <= 1'b0;
            cnt      <= '0;
            state    <= GEN;
          end
        end
        GEN: begin
          s   <= s_next;
          acc <= ks_full;
          cnt <= cnt + 11'd1;
          if (cnt == 11'd7) begin
            out_data  <= byte_q ^ ks_full;
`ifdef TRIVIUM_DEC_KS_OUT_EN
            ks_data   <= ks_full;
`endif
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= WAIT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trivium_decryptor.sv
// Directed bench for trivium_decryptor against a 1-based bit-level Trivium reference.
module tb_trivium_decryptor;

  logic        clk, rst, start;
  logic [79:0] key, iv;
  logic        busy, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data, out_data;
`ifdef TRIVIUM_DEC_KS_OUT_EN
  logic [7:0]  ks_data;
`endif

  int tests = 0;
  int fails = 0;

  localparam logic [79:0] KEY = 80'h9719CFC92A9FF688F9AA;
  localparam logic [79:0] IV  = 80'hECBB76B09AFF71D0D151;

  trivium_decryptor dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .iv(iv), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef TRIVIUM_DEC_KS_OUT_EN
    , .ks_data(ks_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model, indices follow the s1..s288 numbering directly
  bit m [1:288];

  task automatic m_load(input logic [79:0] k, input logic [79:0] v);
    for (int i = 1; i <= 288; i++) m[i] = 1'b0;
    for (int i = 0; i < 80; i++) begin
      m[i + 1]  = k[79 - i];
      m[94 + i] = v[79 - i];
    end
    m[286] = 1'b1; m[287] = 1'b1; m[288] = 1'b1;
  endtask

  task automatic m_round(output bit zo);
    bit a, b, c;
    a = m[66] ^ m[93];
    b = m[162] ^ m[177];
    c = m[243] ^ m[288];
    zo = a ^ b ^ c;
    a = a ^ (m[91] & m[92]) ^ m[171];
    b = b ^ (m[175] & m[176]) ^ m[264];
    c = c ^ (m[286] & m[287]) ^ m[69];
    for (int i = 93; i >= 2; i--)   m[i] = m[i - 1];
    m[1] = c;
    for (int i = 177; i >= 95; i--) m[i] = m[i - 1];
    m[94] = a;
    for (int i = 288; i >= 179; i--) m[i] = m[i - 1];
    m[178] = b;
  endtask

  task automatic m_byte(output logic [7:0] b);
    bit zz;
    for (int k = 0; k < 8; k++) begin
      m_round(zz);
      b[k] = zz;
    end
  endtask

  // pulse start at the next edge (optionally with a competing in_valid) and time the warm-up
  task automatic do_start(input bit with_valid);
    int n;
    bit bad_ir, bad_ov;
    bit zz;
    start = 1'b1; key = KEY; iv = IV;
    if (with_valid) begin in_valid = 1'b1; in_data = 8'hAA; end
    @(posedge clk); @(negedge clk);
    start = 1'b0; in_valid = 1'b0; key = '0; iv = '0;
    m_load(KEY, IV);
    for (int i = 0; i < 1152; i++) m_round(zz);
    chk("start_busy", busy, 1'b1);
    chk("start_in_ready", in_ready, 1'b0);
    n = 0; bad_ir = 0; bad_ov = 0;
    while (busy && n < 2000) begin
      n++;
      if (in_ready) bad_ir = 1;
      if (out_valid) bad_ov = 1;
      @(negedge clk);
    end
    chk("busy_len", n, 1152);
    chk("ready_during_init", bad_ir, 1'b0);
    chk("ovalid_during_init", bad_ov, 1'b0);
    chk("ready_after_init", in_ready, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int bp_pct, output logic [7:0] got);
    int n;
    logic [7:0] ks, exp;
    n = 0;
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    chk("in_ready_wait", in_ready, 1'b1);
    in_valid = 1'b1; in_data = b;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_data = $urandom;
    n = 0;
    while (!out_valid && n < 50) begin n++; @(negedge clk); end
    chk("latency", n, 8);
    m_byte(ks);
    exp = b ^ ks;
    got = out_data;
`ifdef TRIVIUM_DEC_KS_OUT_EN
    chk("ks_data", ks_data, ks);
`endif
    n = 0;
    forever begin
      chk("out_data", out_data, exp);
      chk("out_valid_hold", out_valid, 1'b1);
      out_ready = ($urandom_range(99) >= bp_pct) || (n >= 20);
      n++;
      @(posedge clk); @(negedge clk);
      if (out_ready) break;
    end
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 1'b0);
  endtask

  initial begin
    logic [7:0] ks0, got;
    int n;
    rst = 1'b1; start = 1'b0; key = '0; iv = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 8'h00);

    do_start(1'b0);
    send_byte(8'h00, 0, ks0);

    for (int i = 0; i < 16; i++) send_byte(i[7:0], 50, got);

    // start lands on the 3rd GEN round
    n = 0;
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    in_valid = 1'b1; in_data = 8'h55;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    do_start(1'b0);
    chk("abort_out_valid", out_valid, 1'b0);
    send_byte(8'h00, 0, got);
    chk("restart_ks0", got, ks0);

    // start and in_valid together in WAIT: the byte must not be taken
    do_start(1'b1);
    chk("collide_out_valid", out_valid, 1'b0);
    send_byte(8'h00, 0, got);
    chk("collide_ks0", got, ks0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
